// File: rtl/corelet_ctrl_pkg.sv
// Shared types and instruction-word bit positions for the corelet tile-pass sequencer.
package corelet_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWWr,
        StWLd,
        StWFlush,
        StXWr,
        StXEx,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned InstW       = 34;
    localparam int unsigned InstAcc     = 33;
    localparam int unsigned InstOfifoRd = 6;
    localparam int unsigned InstL0Rd    = 3;
    localparam int unsigned InstL0Wr    = 2;
    localparam int unsigned InstExec    = 1;
    localparam int unsigned InstKload   = 0;

endpackage

// File: rtl/corelet_ctrl.sv
// Sequences one weight-stationary tile pass: weight load, kernel latch, flush,
// activation stream/execute and OFIFO drain with SFP accumulate.
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int unsigned Row   = 8,
    parameter int unsigned Col   = 8,
    parameter int unsigned CntBw = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CntBw-1:0] nij_i,
    input  logic             l0_o_full_i,
    input  logic             ofifo_valid_i,
    output logic [InstW-1:0] inst_o,
    output logic [CntBw-1:0] mem_addr_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CntBw-1:0] RowLast   = CntBw'(Row - 1);
    localparam logic [CntBw-1:0] FlushLast = CntBw'(Row + Col - 1);

    state_e           state_q, state_d;
    logic [CntBw-1:0] cnt_q, cnt_d;
    logic [CntBw-1:0] rd_cnt_q, rd_cnt_d;
    logic [CntBw-1:0] addr_q, addr_d;
    logic [CntBw-1:0] nij_q, nij_d;
    logic [CntBw-1:0] mem_addr_q, mem_addr_d;
    logic [InstW-1:0] inst_q, inst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CntBw-1:0] nij_last;
    logic             rd_en;

    assign nij_last = nij_q - CntBw'(1);
    assign rd_en    = ofifo_valid_i && (rd_cnt_q < nij_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_cnt_d   = rd_cnt_q;
        addr_d     = addr_q;
        nij_d      = nij_q;
        mem_addr_d = mem_addr_q;
        inst_d     = '0;
        done_d     = 1'b0;
        busy_d     = (state_q != StIdle);
        // SFP accumulates the OFIFO word one cycle after it was read out.
        inst_d[InstAcc] = inst_q[InstOfifoRd];

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    nij_d      = nij_i;
                    cnt_d      = '0;
                    rd_cnt_d   = '0;
                    addr_d     = '0;
                    mem_addr_d = '0;
                    state_d    = StWWr;
                end
            end
            StWWr, StXWr: begin
                if (!l0_o_full_i) begin
                    inst_d[InstL0Wr] = 1'b1;
                    mem_addr_d       = addr_q;
                    addr_d           = addr_q + CntBw'(1);
                    cnt_d            = cnt_q + CntBw'(1);
                    if (state_q == StWWr && cnt_q == RowLast) begin
                        cnt_d   = '0;
                        state_d = StWLd;
                    end else if (state_q == StXWr && cnt_q == nij_last) begin
                        cnt_d   = '0;
                        state_d = StXEx;
                    end
                end
            end
            StWLd: begin
                inst_d[InstL0Rd]  = 1'b1;
                inst_d[InstKload] = 1'b1;
                cnt_d             = cnt_q + CntBw'(1);
                if (cnt_q == RowLast) begin
                    cnt_d   = '0;
                    state_d = StWFlush;
                end
            end
            StWFlush: begin
                cnt_d = cnt_q + CntBw'(1);
                if (cnt_q == FlushLast) begin
                    cnt_d   = '0;
                    state_d = (nij_q == '0) ? StDone : StXWr;
                end
            end
            StXEx: begin
                inst_d[InstL0Rd] = 1'b1;
                inst_d[InstExec] = 1'b1;
                if (rd_en) begin
                    inst_d[InstOfifoRd] = 1'b1;
                    rd_cnt_d            = rd_cnt_q + CntBw'(1);
                end
                cnt_d = cnt_q + CntBw'(1);
                if (cnt_q == nij_last) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (rd_en) begin
                    inst_d[InstOfifoRd] = 1'b1;
                    rd_cnt_d            = rd_cnt_q + CntBw'(1);
                end
                // Exiting on the registered count lets the final acc issue first.
                if (rd_cnt_q == nij_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rd_cnt_q   <= '0;
            addr_q     <= '0;
            nij_q      <= '0;
            mem_addr_q <= '0;
            inst_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            addr_q     <= addr_d;
            nij_q      <= nij_d;
            mem_addr_q <= mem_addr_d;
            inst_q     <= inst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst_o     = inst_q;
    assign mem_addr_o = mem_addr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: a phase-layout reference model predicts every
// output cycle of a pass; a negedge monitor pops and compares by cycle stamp.
module tb_corelet_ctrl;
    import corelet_ctrl_pkg::*;

    localparam int Row   = 8;
    localparam int Col   = 8;
    localparam int CntBw = 7;
    localparam int Max   = 512;

    logic             clk_i         = 1'b0;
    logic             rst_i         = 1'b1;
    logic             start_i       = 1'b0;
    logic [CntBw-1:0] nij_i         = '0;
    logic             l0_o_full_i   = 1'b0;
    logic             ofifo_valid_i = 1'b0;
    logic [InstW-1:0] inst_o;
    logic [CntBw-1:0] mem_addr_o;
    logic             busy_o;
    logic             done_o;

    typedef struct {
        int               stamp;
        logic [InstW-1:0] inst;
        logic [CntBw-1:0] addr;
        logic             busy;
        logic             done;
    } rec_t;

    rec_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    corelet_ctrl #(
        .Row  (Row),
        .Col  (Col),
        .CntBw(CntBw)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .nij_i        (nij_i),
        .l0_o_full_i  (l0_o_full_i),
        .ofifo_valid_i(ofifo_valid_i),
        .inst_o       (inst_o),
        .mem_addr_o   (mem_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(string name, int stamp, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, stamp, act, exp);
        end
    endfunction

    // Monitor: compares every record whose cycle stamp has arrived.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk_i);
            while (sb.size() > 0 && sb[0].stamp <= cyc) begin
                r = sb.pop_front();
                if (r.stamp < cyc) begin
                    checks++;
                    fails++;
                    $display("FAIL stale record %0d at cycle %0d", r.stamp, cyc);
                end else begin
                    chk("inst", r.stamp, 64'(inst_o), 64'(r.inst));
                    chk("mem_addr", r.stamp, 64'(mem_addr_o), 64'(r.addr));
                    chk("busy", r.stamp, 64'(busy_o), 64'(r.busy));
                    chk("done", r.stamp, 64'(done_o), 64'(r.done));
                end
            end
        end
    end

    function automatic void push_rec(int stamp, logic [InstW-1:0] inst, logic [CntBw-1:0] addr,
                                     logic busy, logic done);
        rec_t r;
        r.stamp = stamp;
        r.inst  = inst;
        r.addr  = addr;
        r.busy  = busy;
        r.done  = done;
        sb.push_back(r);
    endfunction

    // k indexes cycles relative to the accepting edge (k=0); inputs in full[k]/valid[k]
    // are the values seen at edge k, expectations at k are what that edge registers.
    task automatic run_pass(input int nij, input int stall_pct, input int stall_from,
                            input int valid_from, input bit abort, input bit restart);
        bit               full[Max];
        bit               valid[Max];
        bit               wr[Max];
        logic [InstW-1:0] ei[Max];
        logic [CntBw-1:0] wa[Max];
        logic [CntBw-1:0] cur;
        int t, x0, nrd, last_rd, done_k, abort_k, restart_k, fl0, base, last;

        x0 = 0;
        for (int k = 0; k < Max; k++) begin
            full[k]  = ($urandom_range(99) < stall_pct) ||
                       (stall_from >= 0 && k >= stall_from && k < stall_from + 3);
            valid[k] = (valid_from >= 0) ? (k >= valid_from) : ($urandom_range(1) == 1);
            wr[k]    = 1'b0;
            ei[k]    = '0;
            wa[k]    = '0;
        end

        t = 1;
        for (int i = 0; i < Row; i++) begin
            while (full[t]) t++;
            wr[t] = 1'b1;
            wa[t] = CntBw'(i);
            ei[t][InstL0Wr] = 1'b1;
            t++;
        end
        for (int i = 0; i < Row; i++) begin
            ei[t][InstL0Rd]  = 1'b1;
            ei[t][InstKload] = 1'b1;
            t++;
        end
        fl0 = t;
        t   = t + Row + Col;
        if (nij == 0) begin
            done_k = t;
        end else begin
            for (int i = 0; i < nij; i++) begin
                while (full[t]) t++;
                wr[t] = 1'b1;
                wa[t] = CntBw'(Row + i);
                ei[t][InstL0Wr] = 1'b1;
                t++;
            end
            x0 = t;
            for (int i = 0; i < nij; i++) begin
                ei[t][InstL0Rd] = 1'b1;
                ei[t][InstExec] = 1'b1;
                t++;
            end
            for (int k = x0 + nij + 30; k < Max; k++) valid[k] = 1'b1;
            nrd     = 0;
            last_rd = 0;
            for (int e = x0; nrd < nij; e++) begin
                if (valid[e]) begin
                    ei[e][InstOfifoRd] = 1'b1;
                    ei[e+1][InstAcc]   = 1'b1;
                    nrd++;
                    last_rd = e;
                end
            end
            done_k = ((last_rd + 1 > t) ? last_rd + 1 : t) + 1;
        end
        abort_k   = x0 + 1;
        restart_k = fl0 + 3;
        last      = abort ? abort_k : done_k + 1;

        @(posedge clk_i);
        #1;
        base          = cyc + 1;
        start_i       = 1'b1;
        nij_i         = CntBw'(nij);
        l0_o_full_i   = full[0];
        ofifo_valid_i = valid[0];

        cur = '0;
        for (int k = 0; k <= last; k++) begin
            if (abort && k == abort_k) begin
                push_rec(base + k, '0, '0, 1'b0, 1'b0);
            end else begin
                if (wr[k]) cur = wa[k];
                push_rec(base + k, ei[k], cur, (k >= 1 && k <= done_k), (k == done_k));
            end
        end

        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk_i);
            #1;
            if (abort && k == abort_k + 1) begin
                rst_i = 1'b1;
                break;
            end
            start_i       = restart && (k == restart_k);
            nij_i         = CntBw'($urandom_range(20));
            l0_o_full_i   = full[k];
            ofifo_valid_i = valid[k];
        end
        start_i       = 1'b0;
        l0_o_full_i   = 1'b0;
        ofifo_valid_i = 1'b0;
        if (abort) begin
            repeat (2) @(posedge clk_i);
            #1;
            rst_i = 1'b0;
        end
    endtask

    initial begin
        push_rec(2, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        run_pass(4, 0, -1, 41, 1'b0, 1'b0);
        run_pass(4, 0, 3, 41, 1'b0, 1'b0);
        run_pass(0, 0, -1, -1, 1'b0, 1'b0);
        run_pass(6, 20, -1, -1, 1'b1, 1'b0);
        run_pass(5, 20, -1, -1, 1'b0, 1'b0);
        run_pass(3, 0, -1, -1, 1'b0, 1'b1);
        for (int p = 0; p < 6; p++) begin
            run_pass(int'($urandom_range(12, 1)), 25, -1, -1, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d records left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Sequencer that drives the corelet's 34-bit instruction word through one full weight-stationary tile pass:
- load `row` weight vectors into L0 and latch them into the MAC array;
- flush the array;
- stream `nij` activation vectors through L0 in execute mode;
- drain `nij` output rows from the OFIFO with SFP accumulate.

It sits between the top-level testbench/host and the corelet, and also generates the read address for the memory feeding `l0_in`.

## Interface
- `row`, 8, MAC array rows (weight vectors per tile).
- `col`, 8, MAC array columns.
- `cnt_bw`, 7, width of `nij`, `mem_addr` and internal counters; must hold max(`nij`, `row+col`, `row+nij`).
- `clk` input 1 rising-edge clock.
- `reset` input 1 asynchronous, active-high reset.
- `start` input 1 one-cycle request to begin a pass; sampled only in IDLE.
- `nij` input cnt_bw number of activation vectors; sampled with `start`.
- `l0_o_full` input 1 L0 full; blocks L0 writes.
- `ofifo_valid` input 1 OFIFO has a complete output row available.
- `inst` output 34 registered corelet instruction; unlisted bits drive 0.
- `mem_addr` output cnt_bw registered read address for the `l0_in` source memory.
- `busy` output 1 high from the cycle after `start` is accepted until DONE exits.
- `done` output 1 one-cycle pulse at end of pass.

## Operation
- Instruction bits: `inst[33]` = acc, `inst[6]` = ofifo_rd, `inst[3]` = l0_rd, `inst[2]` = l0_wr, `inst[1]` = execute, `inst[0]` = kernel load.
- All outputs are registered. The value decided in state S at cycle t appears on `inst` at t+1.
- States:
  - IDLE: all outputs 0. On `start`, latch `nij`, clear counters and `mem_addr`, go to W_WR.
  - W_WR: if `!l0_o_full`, set l0_wr=1, increment `mem_addr` and the beat counter. Otherwise l0_wr=0 and all counters hold. After `row` beats, go to W_LD.
  - W_LD: l0_rd=1 and inst[0]=1 for `row` cycles, then W_FLUSH.
  - W_FLUSH: all inst bits 0 for `row+col` cycles. Then go to X_WR, or to DONE if latched `nij`==0.
  - X_WR: same handshake as W_WR, for `nij` beats. `mem_addr` continues from `row`, so activations occupy `row..row+nij-1`.
  - X_EX: l0_rd=1 and inst[1]=1 for `nij` cycles, then DRAIN.
  - DRAIN: wait until the read counter equals `nij`, then DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Read path (active in X_EX and DRAIN):
  - ofifo_rd = `ofifo_valid` && rd_cnt < `nij`; rd_cnt increments on each ofifo_rd.
  - acc is ofifo_rd delayed by one cycle, so SFP accumulates the registered OFIFO output.
- `start` while busy is ignored. `nij` changes during a pass have no effect.

## Timing
- Reset, asynchronous: state=IDLE; `inst`=0, `mem_addr`=0, `busy`=0, `done`=0; all counters 0. Reset mid-pass aborts immediately and no `done` is issued.
- Latency with no L0 stalls, and `start` accepted at cycle 0:
  - l0_wr high cycles 1..row;
  - inst[0] high cycles row+1..2row;
  - flush covers 2row+1..3row+col;
  - activation writes follow, then execute.
- Each L0 stall cycle delays every later event by exactly one cycle.
- `done` is asserted exactly one cycle after the last acc cycle.
- acc is asserted in DONE's predecessor cycle when the last read occurs at the DRAIN exit. DRAIN exits only after that acc cycle has been issued.

## Structure
- Package `corelet_ctrl_pkg`: state enum (IDLE, W_WR, W_LD, W_FLUSH, X_WR, X_EX, DRAIN, DONE) and localparams for the inst bit indices (ACC=33, OFIFO_RD=6, L0_RD=3, L0_WR=2, EXEC=1, KLOAD=0).
- Single module. The beat counter and read counter are in-line; no sub-module.

## Test plan
- row=8, col=8, nij=4, no stalls, `start` at cycle 0:
  - l0_wr on cycles 1–8 with `mem_addr` 0–7;
  - inst[0] on cycles 9–16;
  - zero inst on 17–32;
  - l0_wr on 33–36 with `mem_addr` 8–11;
  - inst[1] on 37–40.
- `ofifo_valid` held high from cycle 40 -> ofifo_rd on 4 consecutive cycles, acc on the following 4, then a single `done` pulse and `busy` falls.
- Hold `l0_o_full` high for 3 cycles during W_WR -> l0_wr and `mem_addr` frozen for those cycles; inst[0] onset delayed by exactly 3 cycles.
- nij=0 -> after flush go straight to DONE: no l0_wr after cycle 8, no ofifo_rd, `done` at cycle 33.
- Assert `reset` during X_EX -> next cycle `inst`=0, `mem_addr`=0, `busy`=0. A new `start` then runs a full correct pass.
- Pulse `start` again during W_FLUSH with a different `nij` -> ignored; the pass completes with the original `nij` read count.
